irq_ctrl: RTL and testbench
===========================

Name: irq_ctrl

Overview:
Machine-mode interrupt controller that sits directly downstream of the machine timer. It collects the timer interrupt, a memory-mapped software interrupt bit and NUM_EXT asynchronous external lines, and drives the mip bits to the CSR file. It selects the highest-priority enabled interrupt and hands it to the core's trap logic through a req/ack handshake. Its registers are memory-mapped on the DBus with the same word-addressed, byte-strobed interface as the timer.

Parameters:
NUM_EXT, 8, number of external interrupt lines (1..32)
SYNC_STAGES, 2, synchronizer depth on each ext_irq line (>=2)

Ports:
clk  input  1  system clock
rst_n  input  1  reset; asynchronous, active-low
rd_en  input  1  DBus read enable
wr_en  input  1  DBus write enable
addr  input  2  DBus word address
wr_data  input  32  DBus write data
wr_strobe  input  4  DBus byte enables
rd_data  output  32  DBus read data
mtime_irq  input  1  timer interrupt level from the machine timer (synchronous to clk)
ext_irq  input  NUM_EXT  external interrupt lines (asynchronous)
mstatus_mie  input  1  global interrupt enable from CSR file
mie  input  3  {MEIE, MTIE, MSIE} from CSR file
mip  output  3  {MEIP, MTIP, MSIP} to CSR file
irq_req  output  1  trap request to core
irq_cause  output  5  mcause exception code of the request (3, 7 or 11)
irq_ack  input  1  core accepted the trap (single-cycle pulse)

Behaviour:
- Reset (asynchronous, rst_n low): synchronizers, edge-detect flops, msip_r, ext_pending, ext_enable and ext_edge all cleared; state=IDLE; irq_req=0; irq_cause=0. mip is combinational and therefore reads 0 after reset unless mtime_irq is high.
- Register map (32-bit words):
  - 0: MSIP. Bit0 = msip_r. Upper bits read 0.
  - 1: EXT_PENDING. W1C on edge-mode bits. Level-mode bits read the synchronized level and ignore writes.
  - 2: EXT_ENABLE. R/W.
  - 3: EXT_EDGE. R/W; 1 = rising-edge triggered, 0 = level.
  - Bits at or above NUM_EXT read 0 and ignore writes.
- Byte strobes: only bytes with wr_strobe set are written or cleared.
- rd_data: combinational. Equals 0 when rd_en is low.
- Synchronizer: ext_irq passes through SYNC_STAGES flops to produce sync. An edge-detect flop sync_d then samples sync.
- Level-mode pending is sync (combinational), so it is visible SYNC_STAGES clocks after the input rises.
- Edge-mode pending is set on sync & ~sync_d, so it is visible SYNC_STAGES+1 clocks after the rising input.
- Edge-mode pending is sticky until W1C. A set and a W1C on the same bit in the same cycle: the set wins.
- mip is combinational:
  - MEIP = |(ext_pending & ext_enable)
  - MTIP = mtime_irq
  - MSIP = msip_r
- Request candidate: cand = mstatus_mie & |(mip & mie).
- Priority: MEI (11) > MSI (3) > MTI (7).
- FSM states IDLE and REQ:
  - IDLE -> REQ when cand = 1. On that clock edge, irq_cause latches the highest-priority cause.
  - REQ: irq_req = 1 and irq_cause stays stable. Source changes and enable changes are ignored while in REQ.
  - REQ -> IDLE on irq_ack. A new request can be raised no earlier than the cycle after returning to IDLE.
  - irq_ack while in IDLE is ignored.
- Latency: cand high at edge N gives irq_req high after edge N.
- A write to msip_r or EXT_PENDING does not itself clear an outstanding REQ; software clears the source before mret.
- Asserting reset mid-REQ drops irq_req immediately (asynchronous) and clears all pending state.

Test Plan:
- Reset, then write MSIP=1 with mstatus_mie=1 and mie=3'b001 -> mip=3'b001; irq_req=1 with irq_cause=3 one clock later; hold for 5 cycles with no ack, then pulse irq_ack -> irq_req=0 the next clock, and re-asserts the following clock because msip_r is still 1.
- mtime_irq=1 and msip_r=1, mie=3'b011 -> irq_cause=3 (MSI beats MTI). Clear MSIP and ack -> next request has irq_cause=7.
- EXT_EDGE=8'h01, EXT_ENABLE=8'h01, pulse ext_irq[0] high for 1 clock -> EXT_PENDING reads 1 exactly 3 clocks later and stays 1 after the line drops. Write EXT_PENDING=1 -> reads 0.
- Level mode on ext_irq[2] with enable set: raise the line -> MEIP after 2 clocks; drop it -> MEIP=0 after 2 clocks; a write of 8'h04 to EXT_PENDING has no effect.
- Edge arrives on the same cycle as a W1C to that bit -> the bit remains 1. A write with wr_strobe=4'b0000 -> no register change.
- Assert rst_n low asynchronously (between clock edges) during REQ -> irq_req, mip[0] and all registers read 0 immediately.

Source files
------------

// File: rtl/irq_ctrl.sv
// irq_ctrl: machine-mode interrupt controller with DBus registers and a req/ack trap handshake.
module irq_ctrl #(
    parameter int NUM_EXT     = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [1:0]         addr,
    input  logic [31:0]        wr_data,
    input  logic [3:0]         wr_strobe,
    output logic [31:0]        rd_data,
    input  logic               mtime_irq,
    input  logic [NUM_EXT-1:0] ext_irq,
    input  logic               mstatus_mie,
    input  logic [2:0]         mie,
    output logic [2:0]         mip,
    output logic               irq_req,
    output logic [4:0]         irq_cause,
    input  logic               irq_ack
);
    typedef enum logic {IDLE, REQ} state_t;

    state_t             r_state;
    logic [NUM_EXT-1:0] r_sync [SYNC_STAGES];
    logic [NUM_EXT-1:0] r_sync_d, r_pend, r_enable, r_edge;
    logic               r_msip, r_irq_req;
    logic [4:0]         r_irq_cause;
    logic [31:0]        w_bmask;
    logic [NUM_EXT-1:0] w_wdata, w_sync, w_rise, w_pending, w_clr;
    logic [2:0]         w_act;
    logic [4:0]         w_cause;
    logic               w_cand, w_unused;

    assign w_bmask   = {{8{wr_strobe[3]}}, {8{wr_strobe[2]}}, {8{wr_strobe[1]}}, {8{wr_strobe[0]}}};
    assign w_wdata   = wr_data[NUM_EXT-1:0] & w_bmask[NUM_EXT-1:0];
    assign w_unused  = ^{wr_data, w_bmask};
    assign w_sync    = r_sync[SYNC_STAGES-1];
    assign w_rise    = w_sync & ~r_sync_d;
    // Level-mode bits expose the synchronized line; edge-mode bits expose the sticky flop.
    assign w_pending = (r_pend & r_edge) | (w_sync & ~r_edge);
    assign w_clr     = (wr_en && addr == 2'd1) ? (w_wdata & r_edge) : '0;
    assign mip       = {|(w_pending & r_enable), mtime_irq, r_msip};
    assign w_act     = mip & mie;
    assign w_cand    = mstatus_mie & |w_act;
    assign w_cause   = w_act[2] ? 5'd11 : w_act[0] ? 5'd3 : 5'd7;
    assign rd_data   = !rd_en        ? '0 :
                       addr == 2'd0  ? {31'b0, r_msip} :
                       addr == 2'd1  ? 32'(w_pending) :
                       addr == 2'd2  ? 32'(r_enable) : 32'(r_edge);
    assign irq_req   = r_irq_req;
    assign irq_cause = r_irq_cause;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
            r_sync_d <= '0;
            r_pend   <= '0;
            r_enable <= '0;
            r_edge   <= '0;
            r_msip   <= 1'b0;
        end else begin
            r_sync[0] <= ext_irq;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
            r_sync_d <= w_sync;
            // Set beats a same-cycle W1C.
            r_pend   <= ((r_pend & ~w_clr) | w_rise) & r_edge;
            if (wr_en && addr == 2'd0 && wr_strobe[0]) r_msip <= wr_data[0];
            if (wr_en && addr == 2'd2) r_enable <= (r_enable & ~w_bmask[NUM_EXT-1:0]) | w_wdata;
            if (wr_en && addr == 2'd3) r_edge <= (r_edge & ~w_bmask[NUM_EXT-1:0]) | w_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_irq_req   <= 1'b0;
            r_irq_cause <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_cand) begin
                    r_state     <= REQ;
                    r_irq_req   <= 1'b1;
                    r_irq_cause <= w_cause;
                end
                REQ: if (irq_ack) begin
                    r_state   <= IDLE;
                    r_irq_req <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: register vector table plus directed sequences for the irq_ctrl handshake and sync paths.
module tb_irq_ctrl;
    logic        clk = 0, rst_n = 0, rd_en = 0, wr_en = 0;
    logic [1:0]  addr = '0;
    logic [31:0] wr_data = '0, rd_data, rv;
    logic [3:0]  wr_strobe = '0;
    logic        mtime_irq = 0, mstatus_mie = 0, irq_ack = 0, irq_req;
    logic [7:0]  ext_irq = '0;
    logic [2:0]  mie = '0, mip;
    logic [4:0]  irq_cause;
    int          checks = 0, errors = 0;

    typedef struct {
        logic [1:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [11];

    irq_ctrl #(.NUM_EXT(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .wr_en(wr_en), .addr(addr),
        .wr_data(wr_data), .wr_strobe(wr_strobe), .rd_data(rd_data),
        .mtime_irq(mtime_irq), .ext_irq(ext_irq), .mstatus_mie(mstatus_mie),
        .mie(mie), .mip(mip), .irq_req(irq_req), .irq_cause(irq_cause), .irq_ack(irq_ack)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s);
        wr_en = 1; addr = a; wr_data = d; wr_strobe = s;
        tick();
        wr_en = 0; wr_strobe = '0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        rd_en = 1; addr = a;
        #1;
        d = rd_data;
        rd_en = 0;
    endtask

    initial begin
        vecs[0]  = '{2'd2, 32'hFFFF_FFFF, 4'hF, 32'h0000_00FF};
        vecs[1]  = '{2'd2, 32'h0000_0012, 4'h0, 32'h0000_00FF};
        vecs[2]  = '{2'd2, 32'h0000_0012, 4'h1, 32'h0000_0012};
        vecs[3]  = '{2'd3, 32'h0000_00A5, 4'h1, 32'h0000_00A5};
        vecs[4]  = '{2'd3, 32'h0000_0000, 4'h2, 32'h0000_00A5};
        vecs[5]  = '{2'd0, 32'hFFFF_FFFF, 4'hF, 32'h0000_0001};
        vecs[6]  = '{2'd0, 32'h0000_0000, 4'h0, 32'h0000_0001};
        vecs[7]  = '{2'd0, 32'h0000_0000, 4'h1, 32'h0000_0000};
        vecs[8]  = '{2'd1, 32'h0000_00FF, 4'hF, 32'h0000_0000};
        vecs[9]  = '{2'd3, 32'h0000_0000, 4'h1, 32'h0000_0000};
        vecs[10] = '{2'd2, 32'h0000_0000, 4'h1, 32'h0000_0000};

        #12;
        chk("reset irq_req", {31'b0, irq_req}, 0);
        chk("reset irq_cause", {27'b0, irq_cause}, 0);
        chk("reset mip", {29'b0, mip}, 0);
        for (int i = 0; i < 4; i++) begin
            rd(2'(i), rv);
            chk($sformatf("reset reg%0d", i), rv, 0);
        end
        #5 rst_n = 1;
        tick();

        for (int i = 0; i < 11; i++) begin
            wr(vecs[i].addr, vecs[i].data, vecs[i].strb);
            rd(vecs[i].addr, rv);
            chk($sformatf("vec%0d", i), rv, vecs[i].exp);
        end
        addr = 2'd2;
        #1;
        chk("rd_en low", rd_data, 0);

        // MSI request, hold without ack, then ack and re-raise
        mstatus_mie = 1; mie = 3'b001;
        wr(2'd0, 32'h1, 4'h1);
        chk("msi mip", {29'b0, mip}, 3'b001);
        chk("msi req latency", {31'b0, irq_req}, 0);
        tick();
        chk("msi req", {31'b0, irq_req}, 1);
        chk("msi cause", {27'b0, irq_cause}, 3);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("msi hold", {31'b0, irq_req}, 1);
        end
        irq_ack = 1; tick(); irq_ack = 0;
        chk("msi ack drop", {31'b0, irq_req}, 0);
        tick();
        chk("msi reassert", {31'b0, irq_req}, 1);
        chk("msi reassert cause", {27'b0, irq_cause}, 3);
        irq_ack = 1; tick(); irq_ack = 0; mstatus_mie = 0;
        tick();
        chk("mie off idle", {31'b0, irq_req}, 0);

        // MSI beats MTI, then MTI after MSIP cleared
        mtime_irq = 1; mie = 3'b011; mstatus_mie = 1;
        tick();
        chk("prio cause", {27'b0, irq_cause}, 3);
        wr(2'd0, 32'h0, 4'h1);
        chk("msip clr keeps req", {31'b0, irq_req}, 1);
        chk("msip clr keeps cause", {27'b0, irq_cause}, 3);
        irq_ack = 1; tick(); irq_ack = 0;
        chk("prio ack", {31'b0, irq_req}, 0);
        tick();
        chk("mti req", {31'b0, irq_req}, 1);
        chk("mti cause", {27'b0, irq_cause}, 7);
        mstatus_mie = 0; irq_ack = 1; tick(); irq_ack = 0; mtime_irq = 0;
        chk("mti ack", {31'b0, irq_req}, 0);
        mie = 3'b000;

        // Edge-mode pending timing and W1C
        wr(2'd3, 32'h1, 4'h1);
        wr(2'd2, 32'h1, 4'h1);
        ext_irq = 8'h01;
        tick(); ext_irq = 8'h00;
        rd(2'd1, rv); chk("edge pend +1", rv, 0);
        tick();
        rd(2'd1, rv); chk("edge pend +2", rv, 0);
        tick();
        rd(2'd1, rv); chk("edge pend +3", rv, 1);
        chk("edge meip", {29'b0, mip}, 3'b100);
        tick();
        rd(2'd1, rv); chk("edge sticky", rv, 1);
        wr(2'd1, 32'h1, 4'h1);
        rd(2'd1, rv); chk("edge w1c", rv, 0);

        // Level mode on line 2
        wr(2'd3, 32'h0, 4'h1);
        wr(2'd2, 32'h4, 4'h1);
        ext_irq = 8'h04;
        tick();
        chk("level +1", {29'b0, mip}, 3'b000);
        tick();
        chk("level +2", {29'b0, mip}, 3'b100);
        rd(2'd1, rv); chk("level pend", rv, 32'h4);
        wr(2'd1, 32'h4, 4'h1);
        rd(2'd1, rv); chk("level w1c ignored", rv, 32'h4);
        ext_irq = 8'h00;
        tick();
        chk("level drop +1", {29'b0, mip}, 3'b100);
        tick();
        chk("level drop +2", {29'b0, mip}, 3'b000);

        // Edge set collides with W1C: set wins
        wr(2'd3, 32'h1, 4'h1);
        ext_irq = 8'h01;
        tick(); ext_irq = 8'h00;
        tick();
        wr(2'd1, 32'h1, 4'h1);
        rd(2'd1, rv); chk("set beats w1c", rv, 1);
        wr(2'd1, 32'h1, 4'h1);
        rd(2'd1, rv); chk("w1c after collision", rv, 0);
        wr(2'd3, 32'h0, 4'h0);
        rd(2'd3, rv); chk("strobe0 edge", rv, 1);
        wr(2'd2, 32'h0, 4'h0);
        rd(2'd2, rv); chk("strobe0 enable", rv, 4);

        // Asynchronous reset mid-REQ
        mie = 3'b001; mstatus_mie = 1;
        wr(2'd0, 32'h1, 4'h1);
        tick();
        chk("pre-reset req", {31'b0, irq_req}, 1);
        #2 rst_n = 0; mstatus_mie = 0;
        #1;
        chk("async rst req", {31'b0, irq_req}, 0);
        chk("async rst mip", {29'b0, mip}, 0);
        for (int i = 0; i < 4; i++) begin
            rd(2'(i), rv);
            chk($sformatf("async rst reg%0d", i), rv, 0);
        end
        #3 rst_n = 1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
